// File: rtl/scl180_sparecell_bank.sv
// Spare-cell bank: NUM_CH tie-lo/tie-hi channels plus one mode-configurable spare flop each.
// Optional 16-bit MISR over spare_q when SPARECELL_SIGNATURE_EN is defined.
module scl180_sparecell_bank #(
    parameter int unsigned NUM_CH = 4
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              cfg_sdi,
    input  logic              cfg_shift,
    input  logic              cfg_update,
    output logic              cfg_sdo,
    input  logic [NUM_CH-1:0] eco_in,
    output logic [NUM_CH-1:0] lo,
    output logic [NUM_CH-1:0] hi,
`ifdef SPARECELL_SIGNATURE_EN
    output logic [NUM_CH-1:0] spare_q,
    output logic [15:0]       sig
`else
    output logic [NUM_CH-1:0] spare_q
`endif
);

    localparam int unsigned MODE_W = 2;
    localparam int unsigned SR_W   = MODE_W * NUM_CH;

    localparam logic [1:0] MODE_TIE    = 2'b00;
    localparam logic [1:0] MODE_HOLD   = 2'b01;
    localparam logic [1:0] MODE_ECO    = 2'b10;
    localparam logic [1:0] MODE_TOGGLE = 2'b11;

    logic [SR_W-1:0]   sr_q;
    logic [SR_W-1:0]   sr_d;
    logic [SR_W-1:0]   cfg_q;
    logic [SR_W-1:0]   cfg_d;
    logic [NUM_CH-1:0] spare_d;

    assign lo      = '0;
    assign hi      = '1;
    // Chain output comes straight from the register so banks can be daisy-chained safely.
    assign cfg_sdo = sr_q[SR_W-1];

    always_comb begin
        sr_d  = cfg_shift ? {sr_q[SR_W-2:0], cfg_sdi} : sr_q;
        // Update samples the pre-edge chain, so a same-cycle shift never leaks in.
        cfg_d = cfg_update ? sr_q : cfg_q;
    end

    always_comb begin
        spare_d = spare_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            unique case (cfg_q[MODE_W*i +: MODE_W])
                MODE_TIE:    spare_d[i] = 1'b0;
                MODE_HOLD:   spare_d[i] = spare_q[i];
                MODE_ECO:    spare_d[i] = eco_in[i];
                MODE_TOGGLE: spare_d[i] = ~spare_q[i];
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sr_q    <= '0;
            cfg_q   <= '0;
            spare_q <= '0;
        end else begin
            sr_q    <= sr_d;
            cfg_q   <= cfg_d;
            spare_q <= spare_d;
        end
    end

`ifdef SPARECELL_SIGNATURE_EN
    logic [15:0] sig_d;

    // CRC-16-CCITT style MISR (x^16+x^12+x^5+1) compacting the pre-edge spare_q.
    always_comb begin
        sig_d = ({sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000)) ^ 16'(spare_q);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sig <= 16'h0000;
        end else begin
            sig <= sig_d;
        end
    end
`endif

endmodule

// File: tb/tb_scl180_sparecell_bank.sv
// Scoreboard bench for scl180_sparecell_bank (NUM_CH=4): stimulus queues expectations by edge
// count, a monitor compares them on the falling edge. Covers SPARECELL_SIGNATURE_EN when defined.
module tb_scl180_sparecell_bank;

    logic       clock = 1'b0;
    logic       resetb;
    logic       cfg_sdi;
    logic       cfg_shift;
    logic       cfg_update;
    logic       cfg_sdo;
    logic [3:0] eco_in;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] spare_q;
`ifdef SPARECELL_SIGNATURE_EN
    logic [15:0] sig;
`endif

    scl180_sparecell_bank #(
        .NUM_CH(4)
    ) dut (
        .clock     (clock),
        .resetb    (resetb),
        .cfg_sdi   (cfg_sdi),
        .cfg_shift (cfg_shift),
        .cfg_update(cfg_update),
        .cfg_sdo   (cfg_sdo),
        .eco_in    (eco_in),
        .lo        (lo),
        .hi        (hi),
`ifdef SPARECELL_SIGNATURE_EN
        .spare_q   (spare_q),
        .sig       (sig)
`else
        .spare_q   (spare_q)
`endif
    );

    always #5 clock = ~clock;

    int ecnt = 0;
    always @(posedge clock) ecnt++;

    localparam int K_Q   = 0;
    localparam int K_SDO = 1;
    localparam int K_LO  = 2;
    localparam int K_HI  = 3;
    localparam int K_SIG = 4;

    typedef struct {
        int          cyc;
        string       name;
        int          kind;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    event rst_ev;

    task automatic expect_at(input int cyc, input string name, input int kind,
                             input logic [15:0] exp);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    function automatic logic [15:0] actual(input int kind);
        logic [15:0] a;
        a = 16'hxxxx;
        case (kind)
            K_Q:   a = {12'h000, spare_q};
            K_SDO: a = {15'h0000, cfg_sdo};
            K_LO:  a = {12'h000, lo};
            K_HI:  a = {12'h000, hi};
`ifdef SPARECELL_SIGNATURE_EN
            K_SIG: a = sig;
`endif
            default: a = 16'hxxxx;
        endcase
        return a;
    endfunction

    task automatic check_due(input int cyc);
        int i;
        logic [15:0] a;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                a = actual(sb[i].kind);
                checks++;
                if (a !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s (edge %0d): got %h, want %h", sb[i].name, cyc, a, sb[i].exp);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    always @(negedge clock) check_due(ecnt);
    always @(rst_ev) check_due(-1);

    task automatic shift_in(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clock);
            cfg_shift = 1'b1;
            cfg_sdi   = v[i];
        end
    endtask

    // Shifts zeros through the chain, expecting cfg_sdo before each shift edge to walk v MSB-first.
    task automatic shift_out_check(input logic [7:0] v, input string name);
        int b;
        b = ecnt;
        for (int i = 0; i < 8; i++) expect_at(b + 1 + i, name, K_SDO, {15'h0, v[7-i]});
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            cfg_shift = 1'b1;
            cfg_sdi   = 1'b0;
        end
        @(negedge clock);
        cfg_shift = 1'b0;
        expect_at(ecnt + 1, {name, "_empty"}, K_SDO, 16'h0);
    endtask

    int u;

    initial begin
        resetb     = 1'b0;
        cfg_sdi    = 1'b0;
        cfg_shift  = 1'b0;
        cfg_update = 1'b0;
        eco_in     = 4'b1111;
        expect_at(1, "rst_spare_q", K_Q, 16'h0);
        expect_at(1, "rst_sdo", K_SDO, 16'h0);
        expect_at(1, "lo_tie", K_LO, 16'h0);
        expect_at(1, "hi_tie", K_HI, 16'hF);
`ifdef SPARECELL_SIGNATURE_EN
        expect_at(1, "rst_sig", K_SIG, 16'h0);
`endif
        repeat (2) @(negedge clock);
        resetb = 1'b1;
        eco_in = 4'b0000;

        // Load 0xAA (all channels ECO), then follow eco_in.
        shift_in(8'hAA);
        @(negedge clock);
        u = ecnt;
        cfg_shift  = 1'b0;
        cfg_update = 1'b1;
        eco_in     = 4'b1011;
        expect_at(u + 1, "sdo_after_aa", K_SDO, 16'h1);
        expect_at(u + 1, "cfg_latency", K_Q, 16'h0);
        expect_at(u + 2, "eco_1011", K_Q, 16'hB);
        expect_at(u + 3, "eco_0100", K_Q, 16'h4);
        expect_at(u + 8, "lo_run", K_LO, 16'h0);
        expect_at(u + 8, "hi_run", K_HI, 16'hF);
        @(negedge clock);
        cfg_update = 1'b0;
        @(negedge clock);
        eco_in = 4'b0100;
        @(negedge clock);
        eco_in = 4'b1111;

        // Drain the chain; cfg must stay 0xAA (ECO) with no update.
        shift_out_check(8'hAA, "chain_aa");
        expect_at(ecnt + 1, "cfg_kept_eco", K_Q, 16'hF);

        // Mixed modes 0xE4: ch3 TOGGLE, ch2 ECO, ch1 HOLD, ch0 TIE.
        shift_in(8'hE4);
        @(negedge clock);
        u = ecnt;
        cfg_shift  = 1'b0;
        cfg_update = 1'b1;
        eco_in     = 4'b0100;
        expect_at(u + 1, "mixed_pre", K_Q, 16'h4);
        expect_at(u + 2, "mixed_e1", K_Q, 16'hC);
        expect_at(u + 3, "mixed_e2", K_Q, 16'h4);
        expect_at(u + 4, "mixed_e3", K_Q, 16'hC);
        expect_at(u + 5, "mixed_e4", K_Q, 16'h4);
        @(negedge clock);
        cfg_update = 1'b0;
        repeat (4) @(negedge clock);

        // Same-cycle shift and update: cfg takes pre-shift 0xAA, chain becomes 0x55.
        shift_in(8'hAA);
        @(negedge clock);
        u = ecnt;
        cfg_shift  = 1'b1;
        cfg_sdi    = 1'b1;
        cfg_update = 1'b1;
        eco_in     = 4'b0101;
        expect_at(u + 2, "simul_cfg_aa", K_Q, 16'h5);
        @(negedge clock);
        cfg_shift  = 1'b0;
        cfg_update = 1'b0;
        cfg_sdi    = 1'b0;
        shift_out_check(8'h55, "simul_sr_55");

        // All-toggle, then asynchronous reset between edges.
        shift_in(8'hFF);
        @(negedge clock);
        u = ecnt;
        cfg_shift  = 1'b0;
        cfg_update = 1'b1;
        eco_in     = 4'b0000;
        expect_at(u + 1, "tog_sdo", K_SDO, 16'h1);
        expect_at(u + 1, "tog_pre", K_Q, 16'h0);
        expect_at(u + 2, "tog_e1", K_Q, 16'hF);
        expect_at(u + 3, "tog_e2", K_Q, 16'h0);
        expect_at(u + 4, "tog_e3", K_Q, 16'hF);
        @(negedge clock);
        cfg_update = 1'b0;
        repeat (3) @(negedge clock);
        #2;
        expect_at(-1, "async_rst_q", K_Q, 16'h0);
        expect_at(-1, "async_rst_sdo", K_SDO, 16'h0);
`ifdef SPARECELL_SIGNATURE_EN
        expect_at(-1, "async_rst_sig", K_SIG, 16'h0);
`endif
        resetb = 1'b0;
        #1;
        ->rst_ev;
        repeat (2) @(negedge clock);
        resetb = 1'b1;
        u = ecnt;
        for (int k = 1; k <= 3; k++) expect_at(u + k, "post_rst_tie", K_Q, 16'h0);
        expect_at(u + 1, "post_rst_sdo", K_SDO, 16'h0);
        repeat (3) @(negedge clock);

`ifdef SPARECELL_SIGNATURE_EN
        // ch0 TOGGLE from a clean start; MISR sequence 0,1,2,5,A after the load edge.
        shift_in(8'h03);
        @(negedge clock);
        u = ecnt;
        cfg_shift  = 1'b0;
        cfg_update = 1'b1;
        expect_at(u + 1, "sig_e0", K_SIG, 16'h0000);
        expect_at(u + 2, "sig_e1", K_SIG, 16'h0000);
        expect_at(u + 3, "sig_e2", K_SIG, 16'h0001);
        expect_at(u + 4, "sig_e3", K_SIG, 16'h0002);
        expect_at(u + 5, "sig_e4", K_SIG, 16'h0005);
        expect_at(u + 6, "sig_e5", K_SIG, 16'h000A);
        @(negedge clock);
        cfg_update = 1'b0;
        repeat (6) @(negedge clock);
        resetb = 1'b0;
        @(negedge clock);
        resetb = 1'b1;
        u = ecnt;
        for (int k = 1; k <= 100; k++) expect_at(u + k, "sig_idle", K_SIG, 16'h0000);
        repeat (100) @(negedge clock);
`endif

        repeat (2) @(negedge clock);
        #1;
        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s (edge %0d): got no sample, want %h", sb[i].name, sb[i].cyc, sb[i].exp);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
